// File: rtl/mesm6_timer.sv
// Timer slot bus responder: two down-counting timers sharing one prescaler,
// sticky W1C pending bits and a registered interrupt request for PIC line 1.
module mesm6_timer #(
  parameter int CNT_W = 24,
  parameter int PRE_W = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [14:0] tim_addr,
  input  logic        tim_read,
  input  logic        tim_write,
  input  logic [47:0] tim_wdata,
  output logic [47:0] tim_rdata,
  output logic        tim_done,
  output logic        tim_int
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACK,
    S_HOLD
  } state_t;

  localparam logic [2:0] A_STATUS   = 3'd6;
  localparam logic [2:0] A_PRESCALE = 3'd7;

  state_t state_reg;

  logic [2:0] addr;
  logic       access;
  logic       wr_en;
  logic       unused_bits;

  assign addr        = tim_addr[2:0];
  assign access      = (state_reg == S_IDLE) && (tim_read || tim_write);
  // A simultaneous read and write strobe is treated as a write.
  assign wr_en       = access && tim_write;
  assign unused_bits = ^{tim_addr[14:3], tim_wdata};

  // Shared prescaler
  logic [PRE_W-1:0] prescale_reg;
  logic [PRE_W-1:0] pcnt_reg;
  logic             tick;

  assign tick = (pcnt_reg == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescale_reg <= '0;
      pcnt_reg     <= '0;
    end else if (wr_en && addr == A_PRESCALE) begin
      prescale_reg <= tim_wdata[PRE_W-1:0];
      pcnt_reg     <= tim_wdata[PRE_W-1:0];
    end else if (tick) begin
      pcnt_reg <= prescale_reg;
    end else begin
      pcnt_reg <= pcnt_reg - PRE_W'(1);
    end
  end

  // Per-timer state, exported as packed vectors for the read mux
  logic [1:0]            expire;
  logic [1:0]            ie_vec;
  logic [1:0][2:0]       ctrl_q;
  logic [1:0][CNT_W-1:0] load_q;
  logic [1:0][CNT_W-1:0] count_q;

  for (genvar gi = 0; gi < 2; gi++) begin : timer_g
    localparam logic [2:0] CTRL_A  = 3'(3 * gi);
    localparam logic [2:0] LOAD_A  = 3'(3 * gi + 1);
    localparam logic [2:0] COUNT_A = 3'(3 * gi + 2);

    logic             en_reg;
    logic             reload_reg;
    logic             ie_reg;
    logic [CNT_W-1:0] load_reg;
    logic [CNT_W-1:0] count_reg;

    assign expire[gi]  = tick && en_reg && (count_reg == '0);
    assign ie_vec[gi]  = ie_reg;
    assign ctrl_q[gi]  = {ie_reg, reload_reg, en_reg};
    assign load_q[gi]  = load_reg;
    assign count_q[gi] = count_reg;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        en_reg     <= 1'b0;
        reload_reg <= 1'b0;
        ie_reg     <= 1'b0;
        load_reg   <= '0;
        count_reg  <= '0;
      end else begin
        if (tick && en_reg) begin
          if (count_reg != '0) begin
            count_reg <= count_reg - CNT_W'(1);
          end else if (reload_reg) begin
            count_reg <= load_reg;
          end else begin
            en_reg <= 1'b0;
          end
        end
        // CPU writes come last so they override the timer's own update.
        if (wr_en && addr == CTRL_A) begin
          en_reg     <= tim_wdata[0];
          reload_reg <= tim_wdata[1];
          ie_reg     <= tim_wdata[2];
        end
        if (wr_en && addr == LOAD_A) begin
          load_reg  <= tim_wdata[CNT_W-1:0];
          count_reg <= tim_wdata[CNT_W-1:0];
        end
        if (wr_en && addr == COUNT_A) begin
          count_reg <= tim_wdata[CNT_W-1:0];
        end
      end
    end
  end

  // Pending bits: an expiry in the same cycle as a W1C keeps the bit set.
  logic [1:0] pending_reg;
  logic [1:0] clr;
  logic       int_reg;

  assign clr = (wr_en && addr == A_STATUS) ? tim_wdata[1:0] : 2'b00;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_reg <= 2'b00;
      int_reg     <= 1'b0;
    end else begin
      pending_reg <= (pending_reg & ~clr) | expire;
      int_reg     <= |(pending_reg & ie_vec);
    end
  end

  assign tim_int = int_reg;

  // Read mux, zero-extended to the bus width
  logic [47:0] rd_val;

  always_comb begin
    rd_val = '0;
    case (addr)
      3'd0:       rd_val[2:0]       = ctrl_q[0];
      3'd1:       rd_val[CNT_W-1:0] = load_q[0];
      3'd2:       rd_val[CNT_W-1:0] = count_q[0];
      3'd3:       rd_val[2:0]       = ctrl_q[1];
      3'd4:       rd_val[CNT_W-1:0] = load_q[1];
      3'd5:       rd_val[CNT_W-1:0] = count_q[1];
      A_STATUS:   rd_val[1:0]       = pending_reg;
      A_PRESCALE: rd_val[PRE_W-1:0] = prescale_reg;
      default:    rd_val            = '0;
    endcase
  end

  // Bus handshake: one access per strobe assertion, done pulses for one cycle.
  logic [47:0] rdata_reg;
  logic        done_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
      done_reg  <= 1'b0;
      rdata_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          done_reg  <= 1'b0;
          rdata_reg <= '0;
          if (tim_read || tim_write) begin
            state_reg <= S_ACK;
            done_reg  <= 1'b1;
            rdata_reg <= tim_write ? 48'd0 : rd_val;
          end
        end
        S_ACK: begin
          state_reg <= S_HOLD;
          done_reg  <= 1'b0;
          rdata_reg <= '0;
        end
        S_HOLD: begin
          done_reg  <= 1'b0;
          rdata_reg <= '0;
          if (!tim_read && !tim_write) begin
            state_reg <= S_IDLE;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          done_reg  <= 1'b0;
          rdata_reg <= '0;
        end
      endcase
    end
  end

  assign tim_done  = done_reg;
  assign tim_rdata = rdata_reg;

endmodule

// File: tb/tb_mesm6_timer.sv
// Directed testbench for mesm6_timer: bus handshake, periodic and one-shot
// timers, W1C/expiry and CPU/timer collisions, reset during a transaction.
module tb_mesm6_timer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [14:0] tim_addr;
  logic        tim_read;
  logic        tim_write;
  logic [47:0] tim_wdata;
  logic [47:0] tim_rdata;
  logic        tim_done;
  logic        tim_int;

  int vec_count = 0;
  int miss_count = 0;
  int cyc = 0;
  int e0 = 0;

  mesm6_timer #(.CNT_W(24), .PRE_W(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .tim_addr  (tim_addr),
    .tim_read  (tim_read),
    .tim_write (tim_write),
    .tim_wdata (tim_wdata),
    .tim_rdata (tim_rdata),
    .tim_done  (tim_done),
    .tim_int   (tim_int)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // One bus transaction. cap is the index of the clock edge that sampled it.
  task automatic bus(input logic wr, input logic [2:0] a, input logic [47:0] d,
                     output logic [47:0] rd, output int cap);
    int  i;
    bit  seen;
    @(negedge clk);
    tim_addr  = {12'o7776, a};
    tim_wdata = d;
    tim_write = wr;
    tim_read  = !wr;
    seen = 1'b0;
    rd   = '0;
    cap  = -1;
    for (i = 0; i < 6; i++) begin
      @(negedge clk);
      if (tim_done) begin
        seen = 1'b1;
        rd   = tim_rdata;
        cap  = cyc;
        break;
      end
    end
    vec_count++;
    if (!seen) begin
      miss_count++;
      $display("FAIL bus_timeout addr=%0d: no done within 6 cycles, required 1", a);
    end else if (i != 0) begin
      miss_count++;
      $display("FAIL bus_latency addr=%0d: done after %0d cycles, required 1", a, i + 1);
    end
    $display("txn %s addr=%0d wdata=%0d rdata=%0d edge=%0d", wr ? "wr" : "rd", a, d, rd, cap);
    tim_read  = 1'b0;
    tim_write = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [47:0] d, output int cap);
    logic [47:0] dummy;
    bus(1'b1, a, d, dummy, cap);
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [47:0] rd, output int cap);
    bus(1'b0, a, 48'd0, rd, cap);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [47:0] r;
    int k;
    reset_n   = 1'b0;
    tim_read  = 1'b0;
    tim_write = 1'b0;
    tim_addr  = '0;
    tim_wdata = '0;
    #1;
    vec_count++;
    if (tim_done !== 1'b0 || tim_rdata !== 48'd0 || tim_int !== 1'b0) begin
      miss_count++;
      $display("FAIL reset_outputs: done=%b rdata=%0d int=%b, required 0/0/0", tim_done, tim_rdata, tim_int);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      rd_reg(3'(a), r, k);
      vec_count++;
      if (r !== 48'd0) begin
        miss_count++;
        $display("FAIL reset_reg%0d: read %0d, required 0", a, r);
      end
    end
  endtask

  task automatic test_periodic;
    logic [47:0] r;
    int c, k;
    wr_reg(3'd1, 48'd5, c);
    wr_reg(3'd7, 48'd0, c);
    wr_reg(3'd0, 48'd7, e0);
    wait_cyc(e0 + 6);
    vec_count++;
    if (tim_int !== 1'b0) begin
      miss_count++;
      $display("FAIL periodic_int_early: int=%b, required 0", tim_int);
    end
    wait_cyc(e0 + 7);
    vec_count++;
    if (tim_int !== 1'b1) begin
      miss_count++;
      $display("FAIL periodic_int_rise: int=%b, required 1", tim_int);
    end
    for (int n = 0; n < 3; n++) begin
      rd_reg(3'd2, r, k);
      vec_count++;
      if (r !== 48'(5 - ((k - 1 - e0) % 6))) begin
        miss_count++;
        $display("FAIL periodic_count: read %0d, required %0d", r, 5 - ((k - 1 - e0) % 6));
      end
    end
    rd_reg(3'd6, r, k);
    vec_count++;
    if (r !== 48'd1) begin
      miss_count++;
      $display("FAIL periodic_status: read %0d, required 1", r);
    end
  endtask

  task automatic test_w1c_collision;
    logic [47:0] r;
    int x, y, k;
    x = e0 + 6 * ((cyc + 2 - e0 + 5) / 6);
    wait_cyc(x - 2);
    wr_reg(3'd6, 48'd1, k);
    vec_count++;
    if (k !== x) begin
      miss_count++;
      $display("FAIL w1c_align: write sampled at edge %0d, required %0d", k, x);
    end
    vec_count++;
    if (tim_int !== 1'b1) begin
      miss_count++;
      $display("FAIL w1c_set_wins_int: int=%b, required 1", tim_int);
    end
    rd_reg(3'd6, r, k);
    vec_count++;
    if (r !== 48'd1) begin
      miss_count++;
      $display("FAIL w1c_set_wins: status %0d, required 1", r);
    end
    y = e0 + 1 + 6 * ((cyc + 2 - (e0 + 1) + 5) / 6);
    wait_cyc(y - 2);
    wr_reg(3'd6, 48'd1, k);
    vec_count++;
    if (tim_int !== 1'b0) begin
      miss_count++;
      $display("FAIL w1c_clear_int: int=%b, required 0", tim_int);
    end
    rd_reg(3'd6, r, k);
    vec_count++;
    if (r !== 48'd0) begin
      miss_count++;
      $display("FAIL w1c_clear: status %0d, required 0", r);
    end
  endtask

  task automatic test_count_collision;
    logic [47:0] r;
    int z, k;
    z = e0 + 2 + 6 * ((cyc + 2 - (e0 + 2) + 5) / 6);
    wait_cyc(z - 2);
    wr_reg(3'd2, 48'd100, k);
    vec_count++;
    if (k !== z) begin
      miss_count++;
      $display("FAIL count_align: write sampled at edge %0d, required %0d", k, z);
    end
    rd_reg(3'd2, r, k);
    vec_count++;
    if (r !== 48'd98) begin
      miss_count++;
      $display("FAIL count_cpu_wins: read %0d, required 98", r);
    end
    wr_reg(3'd0, 48'd0, k);
    wr_reg(3'd6, 48'd3, k);
    rd_reg(3'd6, r, k);
    vec_count++;
    if (r !== 48'd0) begin
      miss_count++;
      $display("FAIL count_status_clear: status %0d, required 0", r);
    end
  endtask

  task automatic test_oneshot;
    logic [47:0] r;
    int a, c, t, x1, k;
    wr_reg(3'd7, 48'd3, a);
    wr_reg(3'd4, 48'd2, c);
    wr_reg(3'd3, 48'd5, c);
    t = a + 4;
    while (t <= c) t += 4;
    x1 = t + 8;
    wait_cyc(x1);
    vec_count++;
    if (tim_int !== 1'b0) begin
      miss_count++;
      $display("FAIL oneshot_int_early: int=%b, required 0", tim_int);
    end
    wait_cyc(x1 + 1);
    vec_count++;
    if (tim_int !== 1'b1) begin
      miss_count++;
      $display("FAIL oneshot_int_rise: int=%b, required 1", tim_int);
    end
    rd_reg(3'd6, r, k);
    vec_count++;
    if (r !== 48'd2) begin
      miss_count++;
      $display("FAIL oneshot_status: read %0d, required 2", r);
    end
    rd_reg(3'd3, r, k);
    vec_count++;
    if (r !== 48'd4) begin
      miss_count++;
      $display("FAIL oneshot_ctrl: read %0d, required 4", r);
    end
    rd_reg(3'd5, r, k);
    vec_count++;
    if (r !== 48'd0) begin
      miss_count++;
      $display("FAIL oneshot_count: read %0d, required 0", r);
    end
  endtask

  task automatic test_hold_read;
    logic [47:0] r;
    int k;
    @(negedge clk);
    tim_addr = {12'o7776, 3'd6};
    tim_read = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vec_count++;
      if (i == 0 && (tim_done !== 1'b1 || tim_rdata !== 48'd2)) begin
        miss_count++;
        $display("FAIL hold_first: done=%b rdata=%0d, required 1/2", tim_done, tim_rdata);
      end else if (i != 0 && (tim_done !== 1'b0 || tim_rdata !== 48'd0)) begin
        miss_count++;
        $display("FAIL hold_cycle%0d: done=%b rdata=%0d, required 0/0", i, tim_done, tim_rdata);
      end
    end
    $display("txn rd addr=6 held 5 cycles");
    tim_read = 1'b0;
    rd_reg(3'd6, r, k);
    vec_count++;
    if (r !== 48'd2) begin
      miss_count++;
      $display("FAIL hold_second_read: read %0d, required 2", r);
    end
  endtask

  task automatic test_reset_mid;
    logic [47:0] r;
    int k;
    wr_reg(3'd1, 48'd1, k);
    wr_reg(3'd0, 48'd5, k);
    repeat (20) @(negedge clk);
    rd_reg(3'd6, r, k);
    vec_count++;
    if (r !== 48'd3 || tim_int !== 1'b1) begin
      miss_count++;
      $display("FAIL rst_pre_status: status=%0d int=%b, required 3/1", r, tim_int);
    end
    @(negedge clk);
    tim_addr = {12'o7776, 3'd6};
    tim_read = 1'b1;
    @(posedge clk);
    #1;
    vec_count++;
    if (tim_done !== 1'b1) begin
      miss_count++;
      $display("FAIL rst_in_ack: done=%b, required 1", tim_done);
    end
    reset_n = 1'b0;
    #1;
    vec_count++;
    if (tim_done !== 1'b0 || tim_rdata !== 48'd0 || tim_int !== 1'b0) begin
      miss_count++;
      $display("FAIL rst_async: done=%b rdata=%0d int=%b, required 0/0/0", tim_done, tim_rdata, tim_int);
    end
    @(negedge clk);
    tim_read = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    vec_count++;
    if (tim_int !== 1'b0 || tim_done !== 1'b0) begin
      miss_count++;
      $display("FAIL rst_release: int=%b done=%b, required 0/0", tim_int, tim_done);
    end
    for (int a = 0; a < 8; a++) begin
      rd_reg(3'(a), r, k);
      vec_count++;
      if (r !== 48'd0) begin
        miss_count++;
        $display("FAIL rst_reg%0d: read %0d, required 0", a, r);
      end
    end
  endtask

  initial begin
    test_reset;
    test_periodic;
    test_w1c_collision;
    test_count_collision;
    test_oneshot;
    test_hold_read;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
